// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request, wait states, byte/word/double access.
// Optional DMEM_STATS_EN adds saturating read/write/error counters.
`timescale 1ns/1ps

// state    | meaning
// IDLE     | ready for a request; errors go straight to RESP
// WAIT     | wait-state countdown before the array access
// ACCESS   | access at word index addr[31:2]
// ACCESS2  | second word of a double (index + 1)
// RESP     | one-cycle response pulse
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_stall
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] stat_reads,
    output logic [15:0] stat_writes,
    output logic [15:0] stat_errs
`endif
);
    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [30:0] DEPTH_L = 31'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_L  = 4'(WAIT_CYCLES);
    localparam logic [1:0]  SZ_BYTE = 2'b00;
    localparam logic [1:0]  SZ_WORD = 2'b01;
    localparam logic [1:0]  SZ_DBL  = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_ACCESS2, S_RESP} state_t;

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [63:0] resp_rdata_q, resp_rdata_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [30:0] widx;
    logic        req_err;
    always_comb begin
        widx = {1'b0, req_addr[31:2]};
        case (req_size)
            SZ_BYTE: req_err = (widx >= DEPTH_L);
            SZ_WORD: req_err = (req_addr[1:0] != 2'b00) || (widx >= DEPTH_L);
            SZ_DBL:  req_err = (req_addr[2:0] != 3'b000) || ((widx + 31'd1) >= DEPTH_L);
            default: req_err = 1'b1;
        endcase
    end

    logic [AW-1:0] acc_idx;
    logic [31:0]   mem_rd;
    logic [4:0]    lane_sh;
    logic [7:0]    byte_rd;
    logic [31:0]   merged;
    logic [31:0]   mem_wdata;
    logic          mem_we;

    // Big-endian byte lanes: offset 0 is bits [31:24], offset 3 is bits [7:0].
    always_comb begin
        acc_idx = addr_q[AW+1:2] + AW'(state_q == S_ACCESS2);
        mem_rd  = mem[acc_idx];
        lane_sh = {~addr_q[1:0], 3'b000};
        byte_rd = mem_rd[lane_sh +: 8];
        merged  = mem_rd;
        merged[lane_sh +: 8] = wdata_q[7:0];
        if (state_q == S_ACCESS2)
            mem_wdata = wdata_q[31:0];
        else if (size_q == SZ_BYTE)
            mem_wdata = merged;
        else if (size_q == SZ_WORD)
            mem_wdata = wdata_q[31:0];
        else
            mem_wdata = wdata_q[63:32];
        mem_we = wr_q && ((state_q == S_ACCESS) || (state_q == S_ACCESS2));
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[acc_idx] <= mem_wdata;
    end

    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    size_d  = req_size;
                    addr_d  = req_addr[AW+1:0];
                    wdata_d = req_wdata;
                    if (req_err) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 64'd0;
                    end else begin
                        cnt_d   = WAIT_L;
                        state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1)
                    state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (size_q == SZ_DBL) begin
                    hi_d    = mem_rd;
                    state_d = S_ACCESS2;
                end else begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    if (wr_q)
                        resp_rdata_d = 64'd0;
                    else if (size_q == SZ_BYTE)
                        resp_rdata_d = {56'd0, byte_rd};
                    else
                        resp_rdata_d = {32'd0, mem_rd};
                end
            end
            S_ACCESS2: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = wr_q ? 64'd0 : {hi_q, mem_rd};
            end
            default: state_d = S_IDLE;
        endcase
        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wr_q         <= 1'b0;
            size_q       <= 2'b00;
            addr_q       <= '0;
            wdata_q      <= 64'd0;
            cnt_q        <= 4'd0;
            hi_q         <= 32'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 64'd0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            hi_q         <= hi_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    // Stall drops in RESP so the pipeline advances on the response edge.
    assign mem_stall  = ((state_q == S_IDLE) && req_valid) || (state_q == S_WAIT) ||
                        (state_q == S_ACCESS) || (state_q == S_ACCESS2);

`ifdef DMEM_STATS_EN
    logic [15:0] reads_q, reads_d, writes_q, writes_d, errs_q, errs_d;
    always_comb begin
        reads_d  = reads_q;
        writes_d = writes_q;
        errs_d   = errs_q;
        if (state_q == S_RESP) begin
            if (resp_err_q) begin
                if (errs_q != 16'hFFFF) errs_d = errs_q + 16'd1;
            end else if (wr_q) begin
                if (writes_q != 16'hFFFF) writes_d = writes_q + 16'd1;
            end else begin
                if (reads_q != 16'hFFFF) reads_d = reads_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reads_q  <= 16'd0;
            writes_q <= 16'd0;
            errs_q   <= 16'd0;
        end else begin
            reads_q  <= reads_d;
            writes_q <= writes_d;
            errs_q   <= errs_d;
        end
    end

    assign stat_reads  = reads_q;
    assign stat_writes = writes_q;
    assign stat_errs   = errs_q;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: transaction-level timing/memory model,
// per-cycle compare on the negative edge, directed literals plus randomized traffic.
`timescale 1ns/1ps

module tb_dmem_responder;
    localparam int DEPTH = 256;
    localparam int W     = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_stall;
`ifdef DMEM_STATS_EN
    logic [15:0] stat_reads, stat_writes, stat_errs;
    int          m_reads = 0, m_writes = 0, m_errs = 0;
`endif

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_stall(mem_stall)
`ifdef DMEM_STATS_EN
        , .stat_reads(stat_reads), .stat_writes(stat_writes), .stat_errs(stat_errs)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic chk64(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic chkint(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [31:0] mm [DEPTH];
    bit          busy = 0;
    int          resp_cyc = 0;
    bit          p_w, p_err;
    logic [1:0]  p_s;
    logic [31:0] p_a;
    logic [63:0] p_d;
    logic [63:0] hold = 64'd0;
    logic [63:0] e_rd;
    bit          e_ready, e_resp, e_stall;

    int          acc_count = 0, resp_count = 0, last_acc_cyc = 0, obs_lat = 0;
    logic [63:0] obs_rdata = 64'd0;
    logic        obs_err = 1'b0;
    int          acc_hist[$];

    function automatic bit m_err(input logic [1:0] s, input logic [31:0] a);
        int unsigned idx = {2'b00, a[31:2]};
        case (s)
            2'd0:    return idx >= DEPTH;
            2'd1:    return (a % 4 != 0) || idx >= DEPTH;
            2'd2:    return (a % 8 != 0) || idx + 1 >= DEPTH;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int m_lat(input logic [1:0] s, input bit err);
        if (err) return 1;
        return W + 2 + ((s == 2'd2) ? 1 : 0);
    endfunction

    function automatic logic [63:0] m_load(input logic [1:0] s, input logic [31:0] a);
        int          idx = int'(a[31:2]);
        int          sh  = (3 - int'(a[1:0])) * 8;
        logic [31:0] wv  = mm[idx];
        if (s == 2'd0) return {56'd0, wv[sh +: 8]};
        if (s == 2'd1) return {32'd0, wv};
        return {mm[idx], mm[idx + 1]};
    endfunction

    task automatic m_store(input logic [1:0] s, input logic [31:0] a, input logic [63:0] d);
        int          idx = int'(a[31:2]);
        int          sh  = (3 - int'(a[1:0])) * 8;
        logic [31:0] wv  = mm[idx];
        if (s == 2'd0) begin
            wv[sh +: 8] = d[7:0];
            mm[idx] = wv;
        end else if (s == 2'd1) begin
            mm[idx] = d[31:0];
        end else begin
            mm[idx]     = d[63:32];
            mm[idx + 1] = d[31:0];
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            busy = 0;
            hold = 64'd0;
`ifdef DMEM_STATS_EN
            m_reads = 0; m_writes = 0; m_errs = 0;
`endif
            chk1("rst_req_ready", req_ready, 1'b1);
            chk1("rst_resp_valid", resp_valid, 1'b0);
            chk1("rst_mem_stall", mem_stall, 1'b0);
            chk64("rst_resp_rdata", resp_rdata, 64'd0);
            chk1("rst_resp_err", resp_err, 1'b0);
        end else begin
            e_ready = !busy;
            e_resp  = busy && (cyc == resp_cyc);
            e_stall = (!busy && req_valid) || (busy && cyc < resp_cyc);
            chk1("req_ready", req_ready, e_ready);
            chk1("resp_valid", resp_valid, e_resp);
            chk1("mem_stall", mem_stall, e_stall);
            if (e_resp) begin
                e_rd = (p_err || p_w) ? 64'd0 : m_load(p_s, p_a);
                chk64("resp_rdata", resp_rdata, e_rd);
                chk1("resp_err", resp_err, p_err);
                if (!p_err && p_w) m_store(p_s, p_a, p_d);
                hold = e_rd;
                busy = 0;
`ifdef DMEM_STATS_EN
                if (p_err) m_errs = (m_errs < 65535) ? m_errs + 1 : m_errs;
                else if (p_w) m_writes = (m_writes < 65535) ? m_writes + 1 : m_writes;
                else m_reads = (m_reads < 65535) ? m_reads + 1 : m_reads;
`endif
            end else begin
                chk64("resp_rdata_hold", resp_rdata, hold);
                chk1("resp_err_quiet", resp_err, 1'b0);
            end
`ifdef DMEM_STATS_EN
            chkint("stat_reads", int'(stat_reads), m_reads);
            chkint("stat_writes", int'(stat_writes), m_writes);
            chkint("stat_errs", int'(stat_errs), m_errs);
`endif
            if (resp_valid) begin
                obs_rdata = resp_rdata;
                obs_err   = resp_err;
                obs_lat   = cyc - last_acc_cyc;
                resp_count++;
            end
            if (e_ready && req_valid) begin
                p_w   = req_write;
                p_s   = req_size;
                p_a   = req_addr;
                p_d   = req_wdata;
                p_err = m_err(req_size, req_addr);
                resp_cyc     = cyc + m_lat(req_size, p_err);
                busy         = 1;
                last_acc_cyc = cyc;
                acc_hist.push_back(cyc);
                acc_count++;
            end
        end
    end

    // ---------------- driver ----------------
    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic issue(input bit w, input logic [1:0] s, input logic [31:0] a,
                         input logic [63:0] d, input bit keep);
        int start = acc_count;
        int t = 0;
        req_write = w; req_size = s; req_addr = a; req_wdata = d; req_valid = 1'b1;
        while (acc_count == start && t < 200) begin
            @(posedge clk);
            t++;
        end
        chk1("accept_seen", acc_count != start, 1'b1);
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic txn(input bit w, input logic [1:0] s, input logic [31:0] a,
                       input logic [63:0] d, output logic [63:0] rd, output logic er,
                       output int lat);
        int r0 = resp_count;
        int t = 0;
        issue(w, s, a, d, 1'b0);
        while (resp_count == r0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        chk1("resp_seen", resp_count != r0, 1'b1);
        #1;
        rd = obs_rdata; er = obs_err; lat = obs_lat;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [63:0] rd;
    logic        er;
    int          lat, h0, r0, gap;
    bit          w, keep;
    logic [1:0]  s;
    logic [31:0] a;
    int unsigned r, idx;

    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < DEPTH; i++) txn(1'b1, 2'd1, 32'(i * 4), 64'd0, rd, er, lat);

        // Reset in the middle of the wait states of a store drops the store.
        issue(1'b1, 2'd1, 32'h10, 64'h0000_0000_CAFE_F00D, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk1("async_rst_ready", req_ready, 1'b1);
        chk1("async_rst_resp_valid", resp_valid, 1'b0);
        chk1("async_rst_stall", mem_stall, 1'b0);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        txn(1'b0, 2'd1, 32'h10, 64'd0, rd, er, lat);
        chk64("dropped_store_word", rd, 64'd0);

        txn(1'b1, 2'd1, 32'h20, 64'h0000_0000_DEAD_BEEF, rd, er, lat);
        chkint("store_word_latency", lat, 4);
        txn(1'b0, 2'd1, 32'h20, 64'd0, rd, er, lat);
        chk64("load_word_data", rd, 64'h0000_0000_DEAD_BEEF);
        chk1("load_word_err", er, 1'b0);
        chkint("load_word_latency", lat, 4);

        txn(1'b1, 2'd1, 32'h20, 64'h0000_0000_1122_3344, rd, er, lat);
        txn(1'b1, 2'd0, 32'h21, 64'h0000_0000_0000_00AA, rd, er, lat);
        txn(1'b0, 2'd1, 32'h20, 64'd0, rd, er, lat);
        chk64("byte_rmw_word", rd, 64'h0000_0000_11AA_3344);
        txn(1'b0, 2'd0, 32'h23, 64'd0, rd, er, lat);
        chk64("load_byte_lane3", rd, 64'h44);
        txn(1'b0, 2'd0, 32'h21, 64'd0, rd, er, lat);
        chk64("load_byte_lane1", rd, 64'hAA);

        txn(1'b1, 2'd2, 32'h40, 64'h0102_0304_0506_0708, rd, er, lat);
        chkint("store_double_latency", lat, 5);
        txn(1'b0, 2'd1, 32'h44, 64'd0, rd, er, lat);
        chk64("double_low_word", rd, 64'h0000_0000_0506_0708);
        txn(1'b0, 2'd1, 32'h40, 64'd0, rd, er, lat);
        chk64("double_high_word", rd, 64'h0000_0000_0102_0304);
        txn(1'b0, 2'd2, 32'h40, 64'd0, rd, er, lat);
        chk64("load_double_data", rd, 64'h0102_0304_0506_0708);
        chkint("load_double_latency", lat, 5);

        txn(1'b0, 2'd1, 32'h22, 64'd0, rd, er, lat);
        chk1("misaligned_word_err", er, 1'b1); chk64("misaligned_word_data", rd, 64'd0);
        chkint("misaligned_word_latency", lat, 1);
        txn(1'b0, 2'd2, 32'h44, 64'd0, rd, er, lat);
        chk1("misaligned_double_err", er, 1'b1); chkint("misaligned_double_latency", lat, 1);
        txn(1'b0, 2'd3, 32'h20, 64'd0, rd, er, lat);
        chk1("reserved_size_err", er, 1'b1); chkint("reserved_size_latency", lat, 1);
        txn(1'b0, 2'd1, 32'(DEPTH * 4), 64'd0, rd, er, lat);
        chk1("out_of_range_err", er, 1'b1); chk64("out_of_range_data", rd, 64'd0);
        txn(1'b1, 2'd2, 32'h44, 64'hFFFF_FFFF_FFFF_FFFF, rd, er, lat);
        chk1("misaligned_store_err", er, 1'b1);
        txn(1'b1, 2'd1, 32'h22, 64'hFFFF_FFFF_FFFF_FFFF, rd, er, lat);
        txn(1'b0, 2'd2, 32'h40, 64'd0, rd, er, lat);
        chk64("array_unchanged_double", rd, 64'h0102_0304_0506_0708);
        txn(1'b0, 2'd1, 32'h20, 64'd0, rd, er, lat);
        chk64("array_unchanged_word", rd, 64'h0000_0000_11AA_3344);
        txn(1'b0, 2'd2, 32'((DEPTH - 1) * 4), 64'd0, rd, er, lat);
        chk1("double_past_end_err", er, 1'b1);
        txn(1'b0, 2'd2, 32'((DEPTH - 2) * 4), 64'd0, rd, er, lat);
        chk1("double_at_end_ok", er, 1'b0); chkint("double_at_end_latency", lat, 5);

        // Back-to-back: valid held through RESP; next accept is the cycle after RESP.
        h0 = acc_hist.size();
        r0 = resp_count;
        issue(1'b0, 2'd1, 32'h20, 64'd0, 1'b1);
        issue(1'b0, 2'd2, 32'h40, 64'd0, 1'b1);
        issue(1'b0, 2'd3, 32'h00, 64'd0, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        chkint("b2b_gap_word", acc_hist[h0 + 1] - acc_hist[h0], 5);
        chkint("b2b_gap_double", acc_hist[h0 + 2] - acc_hist[h0 + 1], 6);
        chkint("b2b_accepts", acc_hist.size() - h0, 3);
        chkint("b2b_responses", resp_count - r0, 3);

        for (int n = 0; n < 400; n++) begin
            w = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r = $urandom_range(0, 15);
            if (r == 0) begin
                a = 32'(DEPTH * 4) + 32'($urandom_range(0, 255)) * 4;
            end else if (r == 1) begin
                a = $urandom;
            end else begin
                idx = $urandom_range(0, DEPTH - 1);
                a = idx * 4;
                if (s == 2'd2) a = (idx & ~32'd1) * 4;
                if (s == 2'd0 || r == 2) a = a + $urandom_range(0, 3);
            end
            keep = ($urandom_range(0, 2) == 0);
            issue(w, s, a, {$urandom, $urandom}, keep);
            if (!keep) begin
                gap = $urandom_range(0, 6);
                repeat (gap) begin
                    @(posedge clk); #1;
                end
            end
        end
        req_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
